// File: rtl/obstacle_engine_pkg.sv
// Shared obstacle/Rex geometry, obstacle type codes and the scroll-step helper.
package obstacle_engine_pkg;

   localparam int unsigned NUM_OBS = 4;
   localparam int unsigned SPEED_W = 8;

   localparam logic [7:0] SCREEN_X = 8'd159;
   localparam logic [7:0] REX_X    = 8'd20;
   localparam logic [7:0] REX_W    = 8'd8;
   localparam logic [7:0] REX_H    = 8'd12;
   localparam logic [7:0] REX_HD   = 8'd6;
   localparam logic [7:0] OBS_W    = 8'd6;
   localparam logic [7:0] OBS_H    = 8'd10;
   localparam logic [7:0] BIRD_Y   = 8'd8;
   localparam logic [7:0] BIRD_SPD = 8'd32;
   localparam logic [7:0] INIT_GAP = 8'd40;
   localparam logic [7:0] MIN_GAP  = 8'd24;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic {
      OBS_CACTUS = 1'b0,
      OBS_BIRD   = 1'b1
   } obs_type_e;

   // Pixels scrolled per frame: 1..16, from the top nibble of the game speed
   function automatic logic [7:0] scroll_step(input logic [SPEED_W-1:0] speed);
      return {4'd0, speed[7:4]} + 8'd1;
   endfunction

endpackage

// File: rtl/obstacle_engine_if.sv
// Control/status bundle between RexControl (master) and the obstacle engine (slave).
interface obstacle_engine_if;
   import obstacle_engine_pkg::*;

   logic                   clear;
   logic                   run_en;
   logic                   frame_tick;
   logic [SPEED_W-1:0]     speed;
   logic [7:0]             rex_y;
   logic                   rex_duck;
   logic                   hit_obs;
   logic                   pass_pulse;
   logic [NUM_OBS-1:0]     obs_valid;
   logic [8*NUM_OBS-1:0]   obs_x;
   logic [NUM_OBS-1:0]     obs_type;

   modport master (
      output clear, run_en, frame_tick, speed, rex_y, rex_duck,
      input  hit_obs, pass_pulse, obs_valid, obs_x, obs_type
   );

   modport slave (
      input  clear, run_en, frame_tick, speed, rex_y, rex_duck,
      output hit_obs, pass_pulse, obs_valid, obs_x, obs_type
   );

endinterface

// File: rtl/obstacle_engine_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11), shifts right once per enabled cycle.
module obstacle_engine_lfsr16
   import obstacle_engine_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        clear,
   input  logic        en,
   output logic [15:0] q
);

   logic feedback;

   assign feedback = q[0] ^ q[2] ^ q[3] ^ q[5];

   // Seed on reset/clear, advance when enabled
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q <= LFSR_SEED;
      end else if (clear) begin
         q <= LFSR_SEED;
      end else if (en) begin
         q <= {feedback, q[15:1]};
      end
   end

endmodule

// File: rtl/obstacle_engine.sv
// Obstacle spawn/scroll engine with registered collision check against Rex.
module obstacle_engine
   import obstacle_engine_pkg::*;
(
   input logic              Clk,
   input logic              Reset,
   obstacle_engine_if.slave bus
);

   localparam logic [8:0] REX_RIGHT = {1'b0, REX_X} + {1'b0, REX_W} - 9'd1;

   logic [NUM_OBS-1:0]        valid_q, valid_d;
   logic [NUM_OBS-1:0][7:0]   x_q, x_d;
   logic [NUM_OBS-1:0]        type_q, type_d;
   logic [7:0]                gap_q, gap_d;
   logic                      hit_q, hit_d;
   logic                      pass_q, pass_d;
   logic [NUM_OBS-1:0]        overlap;
   logic [15:0]               lfsr_q;
   logic                      tick;
   logic [7:0]                step;
   logic [7:0]                rex_h;
   logic                      passed;
   logic                      spawned;
   logic                      unused_lfsr;

   // A hit freezes the playfield even while run_en stays high
   assign tick        = bus.frame_tick & bus.run_en & ~hit_q;
   assign step        = scroll_step(bus.speed);
   assign rex_h       = bus.rex_duck ? REX_HD : REX_H;
   assign unused_lfsr = ^lfsr_q[15:6];

   obstacle_engine_lfsr16 u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .clear (bus.clear),
      .en    (tick),
      .q     (lfsr_q)
   );

   // Per-slot box overlap against Rex; sums are 9-bit so nothing wraps
   for (genvar g = 0; g < NUM_OBS; g++) begin : g_coll
      logic [8:0] ox_l, ox_r, oy_b, oy_t, ry_b, ry_t;
      assign ox_l = {1'b0, x_q[g]};
      assign ox_r = ox_l + {1'b0, OBS_W} - 9'd1;
      assign oy_b = (type_q[g] == OBS_BIRD) ? {1'b0, BIRD_Y} : 9'd0;
      assign oy_t = oy_b + {1'b0, OBS_H} - 9'd1;
      assign ry_b = {1'b0, bus.rex_y};
      assign ry_t = ry_b + {1'b0, rex_h} - 9'd1;
      assign overlap[g] = valid_q[g] & (ox_l <= REX_RIGHT) & (ox_r >= {1'b0, REX_X}) &
                          (ry_b <= oy_t) & (ry_t >= oy_b);
   end

   // Frame update: scroll/retire, pass detect, and spawn into pre-scroll free slots
   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      type_d  = type_q;
      gap_d   = gap_q;
      passed  = 1'b0;
      spawned = 1'b0;
      if (tick) begin
         for (int i = 0; i < NUM_OBS; i++) begin
            if (valid_q[i]) begin
               if (x_q[i] < step) begin
                  valid_d[i] = 1'b0;
                  if (x_q[i] >= REX_X) passed = 1'b1;
               end else begin
                  x_d[i] = x_q[i] - step;
                  if ((x_q[i] >= REX_X) && (x_d[i] < REX_X)) passed = 1'b1;
               end
            end
         end
         if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
         end else begin
            for (int i = 0; i < NUM_OBS; i++) begin
               if (!valid_q[i] && !spawned) begin
                  spawned    = 1'b1;
                  valid_d[i] = 1'b1;
                  x_d[i]     = SCREEN_X;
                  type_d[i]  = (lfsr_q[0] && (bus.speed >= BIRD_SPD)) ? OBS_BIRD : OBS_CACTUS;
               end
            end
            // No free slot leaves gap at zero so the spawn retries next frame
            if (spawned) gap_d = MIN_GAP + {3'd0, lfsr_q[5:1]};
         end
      end
      pass_d = tick & passed;
      hit_d  = hit_q | (bus.run_en & (|overlap));
   end

   // State registers; clear behaves like reset and swallows a coincident tick
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q <= '0;
         x_q     <= '0;
         type_q  <= '0;
         gap_q   <= INIT_GAP;
         hit_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else if (bus.clear) begin
         valid_q <= '0;
         x_q     <= '0;
         type_q  <= '0;
         gap_q   <= INIT_GAP;
         hit_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         type_q  <= type_d;
         gap_q   <= gap_d;
         hit_q   <= hit_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.hit_obs    = hit_q;
   assign bus.pass_pulse = pass_q;
   assign bus.obs_valid  = valid_q;
   assign bus.obs_x      = x_q;
   assign bus.obs_type   = type_q;

endmodule
